// File: rtl/pipelined_adder_param.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained slices with valid/ready.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output.
module pipelined_adder_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    localparam int unsigned SW = WIDTH / STAGES;

    // Per-stage state: skewed operands, partially built sum, slice carry, valid.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];

    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    logic adv;

    assign adv      = ~valid_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign a_in[k] = input_a;
            assign b_in[k] = op_sub ? ~input_b : input_b;
            assign s_in[k] = '0;
            assign c_in[k] = carry_in;
            assign v_in[k] = in_valid;
        end else begin : g_next
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = carry_q[k-1];
            assign v_in[k] = valid_q[k-1];
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic overflow_q;
    logic overflow_d;
`endif

    always_comb begin
        logic [SW:0]        slice;
        logic [WIDTH-1:0]   s_new;
        logic               msb_cin;
        slice   = '0;
        s_new   = '0;
        msb_cin = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                    + {{SW{1'b0}}, c_in[k]};
            s_new              = s_in[k];
            s_new[k*SW +: SW]  = slice[SW-1:0];
            if (adv) begin
                a_d[k]     = a_in[k];
                b_d[k]     = b_in[k];
                s_d[k]     = s_new;
                carry_d[k] = slice[SW];
                valid_d[k] = v_in[k];
            end else begin
                a_d[k]     = a_q[k];
                b_d[k]     = b_q[k];
                s_d[k]     = s_q[k];
                carry_d[k] = carry_q[k];
                valid_d[k] = valid_q[k];
            end
        end
        // After the loop, slice/s_new hold the final stage's result.
        msb_cin = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1] ^ s_new[WIDTH-1];
`ifdef OVERFLOW_FLAG_EN
        overflow_d = adv ? (msb_cin ^ slice[SW]) : overflow_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                s_q[k]     <= s_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];

endmodule
